// File: rtl/udma_uart_rx_poller.sv
// UART cfg-port initiator: enables RX polling, polls VALID/DATA and periodically
// ERROR, and buffers received bytes in a small valid/ready FIFO.
module udma_uart_rx_poller #(
  parameter int FIFO_DEPTH      = 4,
  parameter int ERR_POLL_PERIOD = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic [31:0]                 setup_i,
  output logic                        busy_o,
  output logic [31:0]                 cfg_data_o,
  output logic [4:0]                  cfg_addr_o,
  output logic                        cfg_valid_o,
  output logic                        cfg_rwn_o,
  input  logic [31:0]                 cfg_data_i,
  input  logic                        cfg_ready_i,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        err_parity_o,
  output logic                        err_overflow_o,
  input  logic                        err_clr_i
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(ERR_POLL_PERIOD) + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ERR_POLL_PERIOD - 1);
  localparam logic [4:0]  ADDR_SETUP = 5'h09;
  localparam logic [4:0]  ADDR_ERROR = 5'h0A;
  localparam logic [4:0]  ADDR_VALID = 5'h0C;
  localparam logic [4:0]  ADDR_DATA  = 5'h0D;
  localparam logic [31:0] SETUP_RX_EN   = 32'h0000_0200;
  localparam logic [31:0] SETUP_POLL_EN = 32'h0000_0010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG_WR  = 3'd1,
    ST_POLL    = 3'd2,
    ST_DATA    = 3'd3,
    ST_ERR     = 3'd4,
    ST_STOP_WR = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      setup_q, setup_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      cfg_data_q, cfg_data_d;
  logic [4:0]       cfg_addr_q, cfg_addr_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             cfg_rwn_q, cfg_rwn_d;
  logic             done_s, stop_s, push_s, pop_s, full_s;
  logic [1:0]       err_set_s;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rx_valid_q;
  logic             err_par_q, err_par_d, err_ovf_q, err_ovf_d;
  logic             unused_data_s;

  assign done_s        = cfg_valid_q & cfg_ready_i;
  assign stop_s        = stop_pend_q | stop_i;
  assign full_s        = (level_q == LVL_FULL);
  assign pop_s         = rx_ready_i & (level_q != {LVL_W{1'b0}});
  assign unused_data_s = ^cfg_data_i[31:8];

  // Next-state decision, taken only on handshake completion
  always_comb begin
    state_d     = state_q;
    setup_d     = setup_q;
    err_cnt_d   = err_cnt_q;
    push_s      = 1'b0;
    err_set_s   = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          setup_d   = setup_i;
          err_cnt_d = {CNT_W{1'b0}};
          state_d   = ST_CFG_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CFG_WR: begin
        if (done_s) state_d = ST_POLL;
        else        state_d = ST_CFG_WR;
      end
      ST_POLL: begin
        if (done_s) begin
          if (stop_s) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
            state_d   = ST_STOP_WR;
          end else if (err_cnt_q == CNT_LAST) begin
            err_cnt_d = {CNT_W{1'b0}};
            state_d   = ST_ERR;
          end else begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
            // A full FIFO leaves the byte in the UART to be re-polled
            if (cfg_data_i[0] && !full_s) state_d = ST_DATA;
            else                          state_d = ST_POLL;
          end
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_DATA: begin
        if (done_s) begin
          push_s  = ~full_s;
          state_d = stop_s ? ST_STOP_WR : ST_POLL;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_ERR: begin
        if (done_s) begin
          err_set_s = cfg_data_i[1:0];
          state_d   = stop_s ? ST_STOP_WR : ST_POLL;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_STOP_WR: begin
        if (done_s) state_d = ST_IDLE;
        else        state_d = ST_STOP_WR;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE)                stop_pend_d = 1'b0;
    else if (stop_i && state_q != ST_IDLE) stop_pend_d = 1'b1;
    else                                   stop_pend_d = stop_pend_q;
  end

  // Bus request decoded from the upcoming state so every cfg output is a flop
  always_comb begin
    cfg_valid_d = (state_d != ST_IDLE);
    cfg_rwn_d   = 1'b0;
    cfg_addr_d  = 5'h00;
    cfg_data_d  = 32'h0000_0000;
    case (state_d)
      ST_CFG_WR: begin
        cfg_addr_d = ADDR_SETUP;
        cfg_data_d = setup_d | SETUP_RX_EN | SETUP_POLL_EN;
      end
      ST_POLL:  begin cfg_addr_d = ADDR_VALID; cfg_rwn_d = 1'b1; end
      ST_DATA:  begin cfg_addr_d = ADDR_DATA;  cfg_rwn_d = 1'b1; end
      ST_ERR:   begin cfg_addr_d = ADDR_ERROR; cfg_rwn_d = 1'b1; end
      ST_STOP_WR: begin
        cfg_addr_d = ADDR_SETUP;
        cfg_data_d = setup_d & ~SETUP_POLL_EN;
      end
      default: cfg_valid_d = 1'b0;
    endcase
  end

  // FIFO occupancy and sticky error next values; an ERR set beats a clear
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    err_par_d = (err_clr_i ? 1'b0 : err_par_q) | err_set_s[1];
    err_ovf_d = (err_clr_i ? 1'b0 : err_ovf_q) | err_set_s[0];
  end

  // Control and bus-output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      setup_q     <= 32'h0000_0000;
      stop_pend_q <= 1'b0;
      err_cnt_q   <= {CNT_W{1'b0}};
      cfg_valid_q <= 1'b0;
      cfg_rwn_q   <= 1'b0;
      cfg_addr_q  <= 5'h00;
      cfg_data_q  <= 32'h0000_0000;
      err_par_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_q     <= setup_d;
      stop_pend_q <= stop_pend_d;
      err_cnt_q   <= err_cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_rwn_q   <= cfg_rwn_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      err_par_q   <= err_par_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // FIFO storage and pointers; reset discards contents
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      rx_valid_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= cfg_data_i[7:0];
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q    <= level_d;
      rx_valid_q <= (level_d != {LVL_W{1'b0}});
    end
  end

  // busy and cfg_valid share one flop: both mean "not idle"
  assign busy_o         = cfg_valid_q;
  assign cfg_valid_o    = cfg_valid_q;
  assign cfg_rwn_o      = cfg_rwn_q;
  assign cfg_addr_o     = cfg_addr_q;
  assign cfg_data_o     = cfg_data_q;
  assign rx_data_o      = mem_q[rd_ptr_q];
  assign rx_valid_o     = rx_valid_q;
  assign fifo_level_o   = level_q;
  assign err_parity_o   = err_par_q;
  assign err_overflow_o = err_ovf_q;

endmodule

// File: tb/tb_udma_uart_rx_poller.sv
// Bench for udma_uart_rx_poller: a UART responder plus a transaction-level
// reference model, table-driven setup vectors, directed corners and a random soak.
module tb_udma_uart_rx_poller;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 16;
  localparam int K_CFG = 0, K_POLL = 1, K_DATA = 2, K_ERR = 3, K_STOP = 4;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0;
  logic [31:0] setup_i = 32'h0;
  logic        busy_o, cfg_valid_o, cfg_rwn_o;
  logic [31:0] cfg_data_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_i = 32'h0;
  logic        cfg_ready_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic [2:0]  fifo_level_o;
  logic        err_parity_o, err_overflow_o;
  logic        err_clr_i = 1'b0;

  udma_uart_rx_poller #(.FIFO_DEPTH(DEPTH), .ERR_POLL_PERIOD(PERIOD)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
    .setup_i(setup_i), .busy_o(busy_o), .cfg_data_o(cfg_data_o),
    .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .fifo_level_o(fifo_level_o),
    .err_parity_o(err_parity_o), .err_overflow_o(err_overflow_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: expected transaction, byte stream and sticky flags
  bit          m_busy, m_stop, m_par, m_ovf;
  logic [31:0] m_setup;
  int          m_polls, m_level, p_kind;
  int          dut_data_rd, dut_poll_rd;
  logic [31:0] err_word = 32'h0;
  logic [7:0]  exp_q[$];
  logic [7:0]  uart_q[$];

  typedef struct {
    logic [31:0] setup;
    logic [31:0] cfg_wd;
    logic [31:0] stop_wd;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] kaddr(input int k);
    case (k)
      K_POLL:  return 5'h0C;
      K_DATA:  return 5'h0D;
      K_ERR:   return 5'h0A;
      default: return 5'h09;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_stop = 0; m_par = 0; m_ovf = 0; m_setup = 32'h0;
    m_polls = 0; m_level = 0; p_kind = K_CFG;
    exp_q.delete(); uart_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(cfg_valid_o), 32'd0);
    chk({tag, "_rwn"},   32'(cfg_rwn_o), 32'd0);
    chk({tag, "_addr"},  32'(cfg_addr_o), 32'd0);
    chk({tag, "_data"},  cfg_data_o, 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_rxv"},   32'(rx_valid_o), 32'd0);
    chk({tag, "_rxd"},   32'(rx_data_o), 32'd0);
    chk({tag, "_lvl"},   32'(fifo_level_o), 32'd0);
    chk({tag, "_par"},   32'(err_parity_o), 32'd0);
    chk({tag, "_ovf"},   32'(err_overflow_o), 32'd0);
  endtask

  // One clock: record the cycle, advance the model, check, then respond
  task automatic step();
    bit done, pop, st, sp, clr, stop_now;
    logic [31:0] d, su, tmp;
    int lvl_pre, k;
    done = m_busy && cfg_ready_i; d = cfg_data_i; st = start_i; sp = stop_i;
    clr = err_clr_i; su = setup_i; lvl_pre = m_level; k = p_kind;
    pop = rx_ready_i && (m_level != 0);
    if (pop) chk("rx_pop_data", 32'(rx_data_o), 32'(exp_q[0]));
    if (cfg_valid_o && cfg_ready_i && cfg_addr_o == 5'h0D) dut_data_rd++;
    if (cfg_valid_o && cfg_ready_i && cfg_addr_o == 5'h0C) dut_poll_rd++;
    @(posedge clk); #1;
    stop_now = m_stop || sp;
    if (pop) begin void'(exp_q.pop_front()); m_level--; end
    if (clr) begin m_par = 0; m_ovf = 0; end
    if (!m_busy) begin
      if (st) begin m_busy = 1; m_setup = su; m_polls = 0; m_stop = 0; p_kind = K_CFG; end
    end else begin
      if (sp) m_stop = 1;
      if (done) begin
        case (k)
          K_CFG: p_kind = K_POLL;
          K_POLL: begin
            m_polls++;
            if (stop_now) p_kind = K_STOP;
            else if (m_polls == PERIOD) begin p_kind = K_ERR; m_polls = 0; end
            else if (d[0] && lvl_pre < DEPTH) p_kind = K_DATA;
            else p_kind = K_POLL;
          end
          K_DATA: begin
            exp_q.push_back(d[7:0]); m_level++;
            if (uart_q.size() > 0) void'(uart_q.pop_front());
            p_kind = stop_now ? K_STOP : K_POLL;
          end
          K_ERR: begin
            m_ovf = m_ovf | d[0]; m_par = m_par | d[1];
            p_kind = stop_now ? K_STOP : K_POLL;
          end
          default: begin m_busy = 0; m_stop = 0; end
        endcase
      end
    end
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("cfg_valid", 32'(cfg_valid_o), 32'(m_busy));
    chk("fifo_level", 32'(fifo_level_o), 32'(m_level));
    chk("rx_valid", 32'(rx_valid_o), 32'(m_level != 0));
    if (m_level != 0) chk("rx_head", 32'(rx_data_o), 32'(exp_q[0]));
    chk("err_parity", 32'(err_parity_o), 32'(m_par));
    chk("err_overflow", 32'(err_overflow_o), 32'(m_ovf));
    if (m_busy) begin
      chk("cfg_addr", 32'(cfg_addr_o), 32'(kaddr(p_kind)));
      chk("cfg_rwn", 32'(cfg_rwn_o), 32'(p_kind != K_CFG && p_kind != K_STOP));
      if (p_kind == K_CFG) chk("cfg_wdata", cfg_data_o, m_setup | 32'h0000_0210);
      if (p_kind == K_STOP) chk("stop_wdata", cfg_data_o, m_setup & ~32'h0000_0010);
    end
    tmp = $urandom();
    case (p_kind)
      K_POLL:  tmp[0] = (uart_q.size() != 0);
      K_DATA:  tmp[7:0] = (uart_q.size() != 0) ? uart_q[0] : 8'h00;
      K_ERR:   tmp = err_word;
      default: tmp = tmp;
    endcase
    cfg_data_i = tmp;
  endtask

  initial begin
    int n;
    vt[0] = '{32'h0145_0000, 32'h0145_0210, 32'h0145_0000};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEF};
    vt[2] = '{32'h0000_0010, 32'h0000_0210, 32'h0000_0000};
    vt[3] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5668};
    vt[4] = '{32'hA5A5_0000, 32'hA5A5_0210, 32'hA5A5_0000};
    model_reset();
    #1 chk_reset_vals("rst");
    @(posedge clk); #1; rstn_i = 1'b1;

    // Setup word table: SETUP write, one poll, stop, SETUP write with bit4 cleared
    for (int i = 0; i < 5; i++) begin
      setup_i = vt[i].setup; start_i = 1'b1; cfg_ready_i = 1'b0; step(); start_i = 1'b0;
      chk("tbl_busy", 32'(busy_o), 32'd1);
      chk("tbl_cfg_addr", 32'(cfg_addr_o), 32'h09);
      chk("tbl_cfg_data", cfg_data_o, vt[i].cfg_wd);
      cfg_ready_i = 1'b1; step();
      chk("tbl_poll_addr", 32'(cfg_addr_o), 32'h0C);
      cfg_ready_i = 1'b0; stop_i = 1'b1; step(); stop_i = 1'b0;
      cfg_ready_i = 1'b1; step();
      chk("tbl_stop_addr", 32'(cfg_addr_o), 32'h09);
      chk("tbl_stop_data", cfg_data_o, vt[i].stop_wd);
      step();
      chk("tbl_idle", 32'(busy_o), 32'd0);
    end

    // Two bytes with ready tied high: latency and ordering
    uart_q.push_back(8'h5A); uart_q.push_back(8'hC3);
    setup_i = vt[0].setup; start_i = 1'b1; step(); start_i = 1'b0;
    step(); chk("b_poll_addr", 32'(cfg_addr_o), 32'h0C);
    step(); chk("b_data_addr", 32'(cfg_addr_o), 32'h0D);
    chk("b_rxv_early", 32'(rx_valid_o), 32'd0);
    step(); chk("b_rxv", 32'(rx_valid_o), 32'd1); chk("b_head0", 32'(rx_data_o), 32'h5A);
    step(); step(); chk("b_lvl2", 32'(fifo_level_o), 32'd2);
    repeat (3) step();
    rx_ready_i = 1'b1; step();
    chk("b_head1", 32'(rx_data_o), 32'hC3); chk("b_lvl1", 32'(fifo_level_o), 32'd1);
    step(); chk("b_lvl0", 32'(fifo_level_o), 32'd0);
    rx_ready_i = 1'b0;

    // VALID stuck high with no consumer: exactly DEPTH reads, one pop frees one more
    repeat (12) uart_q.push_back(8'($urandom()));
    dut_data_rd = 0;
    repeat (40) step();
    chk("full_reads", 32'(dut_data_rd), 32'd4);
    chk("full_lvl", 32'(fifo_level_o), 32'd4);
    rx_ready_i = 1'b1; step(); rx_ready_i = 1'b0;
    repeat (30) step();
    chk("full_reads_after_pop", 32'(dut_data_rd), 32'd5);

    // Periodic ERROR read, set-beats-clear, later clear, poll spacing
    uart_q.delete();
    rx_ready_i = 1'b1; repeat (6) step(); rx_ready_i = 1'b0;
    err_word = 32'h0000_0002;
    n = 0; while (cfg_addr_o !== 5'h0A && n < 40) begin step(); n++; end
    chk("err_wait", 32'(cfg_addr_o), 32'h0A);
    err_clr_i = 1'b1; step(); dut_poll_rd = 0;
    chk("err_set_wins", 32'(err_parity_o), 32'd1);
    step(); err_clr_i = 1'b0;
    chk("err_cleared", 32'(err_parity_o), 32'd0);
    err_word = 32'h0;
    n = 0; while (cfg_addr_o !== 5'h0A && n < 40) begin step(); n++; end
    chk("err_spacing", 32'(dut_poll_rd), 32'd16);

    // Stop during a stalled DATA read: handshake completes, then SETUP write
    uart_q.push_back(8'h77);
    n = 0; while (cfg_addr_o !== 5'h0D && n < 40) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", 32'(cfg_addr_o), 32'h0D);
      cfg_ready_i = 1'b0; stop_i = (i == 0); step();
    end
    stop_i = 1'b0; cfg_ready_i = 1'b1; step();
    chk("stall_pushed", 32'(rx_data_o), 32'h77);
    chk("stall_stop_addr", 32'(cfg_addr_o), 32'h09);
    chk("stall_stop_bit4", 32'(cfg_data_o[4]), 32'd0);
    step(); chk("stall_idle", 32'(busy_o), 32'd0);
    rx_ready_i = 1'b1; step(); rx_ready_i = 1'b0;

    // Asynchronous reset with three bytes buffered, then a clean restart
    uart_q.push_back(8'hAA); uart_q.push_back(8'hBB); uart_q.push_back(8'hCC);
    setup_i = vt[0].setup; start_i = 1'b1; step(); start_i = 1'b0;
    n = 0; while (fifo_level_o !== 3'd3 && n < 30) begin step(); n++; end
    chk("rst_lvl3", 32'(fifo_level_o), 32'd3);
    #2 rstn_i = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge clk); #1; rstn_i = 1'b1; model_reset();
    setup_i = vt[0].setup; start_i = 1'b1; step(); start_i = 1'b0;
    chk("restart_addr", 32'(cfg_addr_o), 32'h09);
    chk("restart_data", cfg_data_o, 32'h0145_0210);
    step(); chk("restart_poll", 32'(cfg_addr_o), 32'h0C);

    // Random soak against the reference model
    for (int c = 0; c < 800; c++) begin
      cfg_ready_i = ($urandom_range(0, 3) != 0);
      rx_ready_i  = 1'($urandom_range(0, 1));
      err_clr_i   = ($urandom_range(0, 15) == 0);
      err_word    = $urandom();
      start_i     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) uart_q.push_back(8'($urandom()));
      step();
    end
    start_i = 1'b0; err_clr_i = 1'b0; stop_i = 1'b1; step(); stop_i = 1'b0;
    cfg_ready_i = 1'b1;
    n = 0; while (busy_o !== 1'b0 && n < 20) begin step(); n++; end
    chk("soak_idle", 32'(busy_o), 32'd0);
    rx_ready_i = 1'b1; repeat (DEPTH + 1) step(); rx_ready_i = 1'b0;
    chk("soak_drained", 32'(fifo_level_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
